// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding fetches to instruction
// memory, and applies predictor and mispredict redirects ahead of decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        stall_f_i,
  input  logic        pc_redirect_i,
  input  logic [31:0] pc_redirect_target_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
  output logic [31:0] pred_pc_target_f_o,
  output logic        pc_src_pred_f_o
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        req;
  logic        deliver;
  logic        consume;
  logic [31:0] next_pc;
  logic        unused_target_bits;

  assign unused_target_bits = ^pc_redirect_target_i[1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    deliver = ((state_q == StWait) && imem_rvalid_i) || (state_q == StHold);
    consume = deliver && !stall_f_i && !pc_redirect_i;
    next_pc = pred_taken_i ? {pred_target_i[31:2], 2'b00} : pc_q + 32'd4;

    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    req         = 1'b0;
    imem_addr_o = pc_q;

    if (pc_redirect_i) begin
      pc_d = {pc_redirect_target_i[31:2], 2'b00};
      // An in-flight response must be swallowed before the corrected fetch can issue.
      if (((state_q == StWait) || (state_q == StDrop)) && !imem_rvalid_i) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          req     = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid_i) begin
            if (consume) begin
              req         = 1'b1;
              imem_addr_o = next_pc;
              pc_d        = next_pc;
            end else begin
              buf_d   = imem_rdata_i;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (consume) begin
            req         = 1'b1;
            imem_addr_o = next_pc;
            pc_d        = next_pc;
            state_d     = StWait;
          end
        end
        StDrop: begin
          if (imem_rvalid_i) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_comb begin
    if (state_q == StHold) begin
      instr_f_o = buf_q;
    end else if ((state_q == StWait) && imem_rvalid_i) begin
      instr_f_o = imem_rdata_i;
    end else begin
      instr_f_o = NOP_INSTR;
    end
  end

  // Reset forces the request low even though the reset state is StReq.
  assign imem_req_o         = req & reset_n_i;
  assign pc_f_o             = pc_q;
  assign pc_plus4_f_o       = pc_q + 32'd4;
  assign pred_pc_target_f_o = pred_target_i;
  assign pc_src_pred_f_o    = pred_taken_i & deliver;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable memory model plus an address scoreboard
// checked against every instruction that decode consumes.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset_n, stall, redirect, pred_taken, rvalid, req, src_pred;
  logic [31:0] redirect_target, pred_target, rdata, addr, instr, pc, pc4, pred_tgt_f;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic        req_seen;
  logic [31:0] addr_seen;
  logic [31:0] sb_q[$];
  logic [31:0] exp_addr;
  bit          found;

  fetch_stage dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .stall_f_i           (stall),
    .pc_redirect_i       (redirect),
    .pc_redirect_target_i(redirect_target),
    .pred_taken_i        (pred_taken),
    .pred_target_i       (pred_target),
    .imem_req_o          (req),
    .imem_addr_o         (addr),
    .imem_rvalid_i       (rvalid),
    .imem_rdata_i        (rdata),
    .instr_f_o           (instr),
    .pc_f_o              (pc),
    .pc_plus4_f_o        (pc4),
    .pred_pc_target_f_o  (pred_tgt_f),
    .pc_src_pred_f_o     (src_pred)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0] ^ 24'h5a5a5a, 8'h6f};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Memory model: responds lat cycles after a request, reset by the same reset.
  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    pend   = 1'b0;
    cnt    = 0;
    paddr  = '0;
    forever begin
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (req_seen) begin
          pend  = 1'b1;
          cnt   = lat;
          paddr = addr_seen;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(paddr);
            pend   = 1'b0;
          end
        end
      end
    end
  end

  // Request sampler and consume-side scoreboard.
  initial begin
    req_seen  = 1'b0;
    addr_seen = '0;
    forever begin
      @(negedge clk);
      req_seen  = reset_n & req;
      addr_seen = addr;
      if (reset_n) begin
        if (instr !== NOP && !stall && !redirect) begin
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: consumed pc %h instr %h, want no instruction", pc, instr);
          end else begin
            exp_addr = sb_q.pop_front();
            if (pc !== exp_addr || instr !== mem_word(exp_addr)) begin
              n_err++;
              $display("FAIL sb_consume: got pc %h instr %h want pc %h instr %h",
                       pc, instr, exp_addr, mem_word(exp_addr));
            end
          end
          n_cmp++;
        end
        if (req) begin
          if (pend !== 1'b0) begin
            n_err++;
            $display("FAIL one_outstanding: got req with pending %b want 0", pend);
          end
          n_cmp++;
          sb_q.push_back(addr);
        end
      end
    end
  end

  task automatic do_reset(input int l);
    reset_n         = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    pred_taken      = 1'b0;
    pred_target     = '0;
    redirect_target = '0;
    lat             = l;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [31:0] target, input string name);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (pc === target) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_err++;
      $display("FAIL %s_timeout: got pc %h want %h", name, pc, target);
    end
    n_cmp++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; pred_taken = 1'b0;
    pred_target = '0; redirect_target = '0; lat = 1;
    @(negedge clk);
    if (instr !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
    n_cmp++;
    if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_cmp++;
    if (req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", req); end
    n_cmp++;
    @(posedge clk);
    #1;
    sb_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'h0) begin
      n_err++; $display("FAIL rst_first_req: got %b/%h want 1/00000000", req, addr);
    end
    n_cmp++;
    if (instr !== NOP) begin n_err++; $display("FAIL rst_rel_instr: got %h want %h", instr, NOP); end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    do_reset(1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req !== 1'b1 || addr !== 32'(4 * c)) begin
        n_err++; $display("FAIL b2b_req%0d: got %b/%h want 1/%h", c, req, addr, 32'(4 * c));
      end
      n_cmp++;
      if (c > 0) begin
        if (pc !== 32'(4 * (c - 1)) || instr !== mem_word(32'(4 * (c - 1)))) begin
          n_err++; $display("FAIL b2b_out%0d: got pc %h instr %h want pc %h", c, pc, instr,
                            32'(4 * (c - 1)));
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_latency;
    do_reset(3);
    pred_taken  = 1'b1;
    pred_target = 32'h40;
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'h0) begin
      n_err++; $display("FAIL lat_req0: got %b/%h want 1/00000000", req, addr);
    end
    n_cmp++;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      if (instr !== NOP || req !== 1'b0 || src_pred !== 1'b0) begin
        n_err++; $display("FAIL lat_bubble%0d: got instr %h req %b pred %b want %h 0 0",
                          c, instr, req, src_pred, NOP);
      end
      n_cmp++;
    end
    @(posedge clk);
    #1;
    pred_taken = 1'b0;
    @(negedge clk);
    if (instr !== mem_word(32'h0) || req !== 1'b1 || addr !== 32'h4) begin
      n_err++; $display("FAIL lat_data: got instr %h req %b addr %h want %h 1 00000004",
                        instr, req, addr, mem_word(32'h0));
    end
    n_cmp++;
  endtask

  task automatic test_stall;
    do_reset(1);
    wait_pc(32'h10, "stall");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (instr !== mem_word(32'h10) || pc !== 32'h10 || req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: got instr %h pc %h req %b want %h 00000010 0",
                          k, instr, pc, req, mem_word(32'h10));
      end
      n_cmp++;
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    @(negedge clk);
    if (instr !== mem_word(32'h10) || req !== 1'b1 || addr !== 32'h14) begin
      n_err++; $display("FAIL stall_release: got instr %h req %b addr %h want %h 1 00000014",
                        instr, req, addr, mem_word(32'h10));
    end
    n_cmp++;
  endtask

  task automatic test_predict;
    do_reset(1);
    wait_pc(32'h20, "pred");
    pred_taken  = 1'b1;
    pred_target = 32'h100;
    @(negedge clk);
    if (src_pred !== 1'b1 || pred_tgt_f !== 32'h100) begin
      n_err++; $display("FAIL pred_out: got %b/%h want 1/00000100", src_pred, pred_tgt_f);
    end
    n_cmp++;
    if (pc4 !== 32'h24) begin n_err++; $display("FAIL pred_pc4: got %h want 00000024", pc4); end
    n_cmp++;
    if (req !== 1'b1 || addr !== 32'h100) begin
      n_err++; $display("FAIL pred_req: got %b/%h want 1/00000100", req, addr);
    end
    n_cmp++;
    @(posedge clk);
    #1;
    pred_taken = 1'b0;
    @(negedge clk);
    if (pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      n_err++; $display("FAIL pred_target_fetch: got pc %h instr %h want 00000100 %h",
                        pc, instr, mem_word(32'h100));
    end
    n_cmp++;
  endtask

  task automatic test_redirect;
    do_reset(3);
    @(negedge clk);
    @(posedge clk);
    #1;
    redirect        = 1'b1;
    redirect_target = 32'h203;
    sb_q.delete();
    @(negedge clk);
    if (req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %b want 0", req); end
    n_cmp++;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      if (instr !== NOP || req !== 1'b0 || pc !== 32'h200) begin
        n_err++; $display("FAIL redir_drop%0d: got instr %h req %b pc %h want %h 0 00000200",
                          c, instr, req, pc, NOP);
      end
      n_cmp++;
    end
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'h200) begin
      n_err++; $display("FAIL redir_new_req: got %b/%h want 1/00000200", req, addr);
    end
    n_cmp++;
    repeat (3) @(negedge clk);
    if (instr !== mem_word(32'h200)) begin
      n_err++; $display("FAIL redir_data: got %h want %h", instr, mem_word(32'h200));
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_wait;
    do_reset(3);
    wait_pc(32'h8, "midrst");
    reset_n = 1'b0;
    #1;
    if (instr !== NOP || pc !== 32'h0 || req !== 1'b0) begin
      n_err++; $display("FAIL midrst_out: got instr %h pc %h req %b want %h 00000000 0",
                        instr, pc, req, NOP);
    end
    n_cmp++;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'h0) begin
      n_err++; $display("FAIL midrst_req: got %b/%h want 1/00000000", req, addr);
    end
    n_cmp++;
    repeat (3) @(negedge clk);
    if (instr !== mem_word(32'h0) || pc !== 32'h0) begin
      n_err++; $display("FAIL midrst_data: got instr %h pc %h want %h 00000000",
                        instr, pc, mem_word(32'h0));
    end
    n_cmp++;
  endtask

  task automatic test_wrap;
    do_reset(1);
    redirect        = 1'b1;
    redirect_target = 32'hffff_fffe;
    sb_q.delete();
    @(negedge clk);
    if (req !== 1'b0) begin n_err++; $display("FAIL wrap_redir_req: got %b want 0", req); end
    n_cmp++;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'hffff_fffc || pc4 !== 32'h0) begin
      n_err++; $display("FAIL wrap_top: got req %b addr %h pc4 %h want 1 fffffffc 00000000",
                        req, addr, pc4);
    end
    n_cmp++;
    @(negedge clk);
    if (instr !== mem_word(32'hffff_fffc) || req !== 1'b1 || addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_next: got instr %h req %b addr %h want %h 1 00000000",
                        instr, req, addr, mem_word(32'hffff_fffc));
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_latency();
    test_stall();
    test_predict();
    test_redirect();
    test_reset_mid_wait();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
